pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control unit for the five-stage MIPS datapath. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC by generating write-enable, hold, bubble and flush controls. It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits. It also keeps saturating stall and flush statistics and raises a sticky memory-timeout error.

## Interface
Parameters:
- CNT_W, 16, width of the statistics counters
- MAX_WAIT, 15, consecutive mem_busy cycles before timeout is flagged

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- ex_MemRead  in  1  MemRead of instruction in EX (ID/EX output)
- ex_rt  in  5  rt field of instruction in EX (ID/EX output)
- ex_branch_taken  in  1  (Branch & zero) | (BranchNE & ~zero), resolved in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID load NOP
- idex_bubble  out  1  ID/EX loads all-zero control fields
- idex_hold  out  1  ID/EX keeps contents
- exmem_hold  out  1  EX/MEM keeps contents
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of branch flushes
- mem_timeout  out  1  sticky: mem_busy lasted MAX_WAIT cycles

## Operation
- Clocking and reset: one clock, clk; rst is synchronous and active-high.
- FSM states: RUN and MEMWAIT. Control outputs are combinational from the current state and inputs. State, counters and mem_timeout are registered.
- Reset (rst high at a posedge):
  - State goes to RUN; stall_cnt = 0, flush_cnt = 0, mem_timeout = 0; wait counter cleared.
  - While rst is high, controls are forced to pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_bubble = 1, idex_hold = 0, exmem_hold = 0.
- Default (RUN, no event): pc_write = 1, ifid_write = 1; all other controls 0.
- Priority within a cycle: mem_busy > ex_branch_taken > load-use.
- Memory wait (mem_busy = 1, any state):
  - pc_write = 0, ifid_write = 0, idex_hold = 1, exmem_hold = 1; no bubble or flush.
  - Next state is MEMWAIT; the wait counter increments and stall_cnt increments.
  - When the wait counter reaches MAX_WAIT, mem_timeout is set. It stays set until rst. Stalling continues as long as mem_busy is high.
  - When mem_busy drops, the next state is RUN and the wait counter clears.
  - Branch and load-use inputs are ignored during a wait. EX is frozen, so they are re-evaluated on the first non-busy cycle.
- Branch taken (ex_branch_taken = 1, mem_busy = 0):
  - pc_write = 1 (PC loads the target), ifid_write = 1, ifid_flush = 1, idex_bubble = 1.
  - flush_cnt increments.
  - Any simultaneous load-use condition is discarded, because the ID instruction is squashed.
- Load-use (mem_busy = 0, ex_branch_taken = 0):
  - Condition: ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
  - Response: pc_write = 0, ifid_write = 0, idex_bubble = 1, for exactly one cycle.
  - stall_cnt increments.
  - The next cycle sees the bubble in EX (ex_MemRead = 0), so the stall releases with no extra state.
- Counters saturate at all-ones and never wrap.

## Timing
- Hazard response has zero latency: controls are valid in the same cycle as the causing inputs and take effect at the next posedge.
- Load-use costs exactly 1 bubble cycle; a taken branch costs 2 squashed instructions (IF and ID).
- MEMWAIT stalls for N cycles while mem_busy is high for N cycles; execution resumes on the first cycle mem_busy is low.
- mem_timeout is asserted on the posedge after the MAX_WAIT-th consecutive busy cycle.
- Statistics counters update one posedge after the event cycle.
- Reset mid-wait abandons MEMWAIT immediately: next state is RUN and the wait counter clears.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEMWAIT);
  - the REG_ZERO = 5'd0 constant;
  - a struct bundling the six control outputs, for reuse by the pipeline top.
- Sub-module load_use_detect (purely combinational) holds the register-compare logic above, so it can be reused for forwarding checks.
- Estimated size: about 150–250 lines of RTL.

## Test plan
- Load-use: lw with ex_rt = 8, id_rs = 8 -> one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cnt goes 0 -> 1; the next cycle returns to defaults.
- rt and $zero checks:
  - ex_rt = 8, id_rt = 8, id_uses_rt = 0 -> no stall.
  - ex_rt = 0, id_rs = 0 -> no stall.
- Branch over load-use: ex_branch_taken = 1 with a simultaneous load-use match -> ifid_flush = 1, idex_bubble = 1, pc_write = 1; flush_cnt = 1; stall_cnt unchanged.
- Memory wait with branch: mem_busy high for 3 cycles with ex_branch_taken = 1 -> 3 hold cycles with no flush, stall_cnt = 3, then a flush on cycle 4.
- Timeout: MAX_WAIT = 4, mem_busy high for 6 cycles -> mem_timeout rises after cycle 4, stays 1 after mem_busy drops, and clears only on rst.
- Reset during MEMWAIT: rst asserted in the second busy cycle -> next cycle in RUN with counters 0, and ifid_flush = 1, idex_bubble = 1 while rst is high.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bundle of the six pipeline-register / PC controls, MSB first.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_hold;
        logic exmem_hold;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational register-compare between a load in EX and the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    logic rsMatch;
    logic rtMatch;

    // $zero is never a real dependency, so a load targeting r0 cannot stall.
    always_comb begin
        rsMatch = (ex_rt == id_rs);
        rtMatch = id_uses_rt && (ex_rt == id_rt);
        hazard  = ex_MemRead && (ex_rt != REG_ZERO) && (rsMatch || rtMatch);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for load-use stalls, EX-resolved branch flushes and data-memory waits,
// with saturating stall/flush statistics and a sticky memory-timeout flag.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, waitBase, waitInc;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              timeout_q, timeout_d;
    logic              loadUse;
    ctrl_t             ctrl;

    load_use_detect u_load_use_detect (
        .ex_MemRead (ex_MemRead),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .hazard     (loadUse)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        timeout_d = timeout_q;
        ctrl      = '0;
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;

        // A busy cycle entered from RUN starts a fresh run of consecutive waits.
        waitBase = (state_q == MEMWAIT) ? wait_q : '0;
        waitInc  = (waitBase == WAIT_MAX) ? waitBase : waitBase + WAIT_W'(1);

        if (rst) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
        end else if (mem_busy) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_hold  = 1'b1;
            ctrl.exmem_hold = 1'b1;
            state_d = MEMWAIT;
            wait_d  = waitInc;
            stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
            if (waitInc == WAIT_MAX) begin
                timeout_d = 1'b1;
            end
        end else begin
            state_d = RUN;
            wait_d  = '0;
            // The squashed ID instruction makes any coincident load-use irrelevant.
            if (ex_branch_taken) begin
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_bubble = 1'b1;
                flush_d = (flush_q == '1) ? flush_q : flush_q + CNT_W'(1);
            end else if (loadUse) begin
                ctrl.pc_write    = 1'b0;
                ctrl.ifid_write  = 1'b0;
                ctrl.idex_bubble = 1'b1;
                stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign idex_hold   = ctrl.idex_hold;
    assign exmem_hold  = ctrl.exmem_hold;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus hand-built wait/timeout/reset sequences.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int MAXW = 4;

    localparam ctrl_t DEF_C = 6'b110000;
    localparam ctrl_t LU_C  = 6'b000100;
    localparam ctrl_t BR_C  = 6'b111100;
    localparam ctrl_t MW_C  = 6'b000011;
    localparam ctrl_t RST_C = 6'b001100;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_MemRead, ex_branch_taken, mem_busy;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_timeout;

    typedef struct {
        string      name;
        logic       r, b, br, mr;
        logic [4:0] exrt, idrs, idrt;
        logic       ur;
        ctrl_t      exp;
    } vec_t;

    typedef struct {
        string         name;
        ctrl_t         ctrl;
        logic [CW-1:0] stall, flush;
        logic          to;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[10];

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] mStall = '0, mFlush = '0;
    logic          mTo = 1'b0;
    int            mWait = 0;

    pipe_hazard_ctrl #(.CNT_W(CW), .MAX_WAIT(MAXW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_MemRead      (ex_MemRead),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .idex_hold       (idex_hold),
        .exmem_hold      (exmem_hold),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout     (mem_timeout)
    );

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic checkOutput();
        sb_t   e;
        ctrl_t got;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: got no entry want one");
            return;
        end
        e   = sbq.pop_front();
        got = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold};
        total++;
        if (got !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL %s ctrl: got %b want %b", e.name, got, e.ctrl);
        end
        total++;
        if (stall_cnt !== e.stall) begin
            bad++;
            $display("[TB] FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.stall);
        end
        total++;
        if (flush_cnt !== e.flush) begin
            bad++;
            $display("[TB] FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.flush);
        end
        total++;
        if (mem_timeout !== e.to) begin
            bad++;
            $display("[TB] FAIL %s mem_timeout: got %b want %b", e.name, mem_timeout, e.to);
        end
    endtask

    // Drive one cycle, queue the expectation, check it, then advance the reference counters.
    task automatic applyStimulus(input string name, input logic r, input logic b, input logic br,
                                 input logic mr, input logic [4:0] exrt, input logic [4:0] idrs,
                                 input logic [4:0] idrt, input logic ur, input ctrl_t exp);
        sb_t e;
        @(negedge clk);
        rst = r; mem_busy = b; ex_branch_taken = br; ex_MemRead = mr;
        ex_rt = exrt; id_rs = idrs; id_rt = idrt; id_uses_rt = ur;
        e.name = name; e.ctrl = exp; e.stall = mStall; e.flush = mFlush; e.to = mTo;
        sbq.push_back(e);
        #1;
        checkOutput();
        if (r) begin
            mStall = '0; mFlush = '0; mTo = 1'b0; mWait = 0;
        end else if (b) begin
            if (mStall != '1) mStall = mStall + 1'b1;
            mWait++;
            if (mWait >= MAXW) mTo = 1'b1;
        end else begin
            mWait = 0;
            if (exp == LU_C && mStall != '1) mStall = mStall + 1'b1;
            if (exp == BR_C && mFlush != '1) mFlush = mFlush + 1'b1;
        end
    endtask

    task automatic idle(input string name);
        applyStimulus(name, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, DEF_C);
    endtask

    task automatic doReset(input string name);
        applyStimulus(name, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RST_C);
    endtask

    task automatic busy(input string name);
        applyStimulus(name, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, MW_C);
    endtask

    initial begin
        rst = 1'b1; mem_busy = 0; ex_branch_taken = 0; ex_MemRead = 0;
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        repeat (2) @(posedge clk);

        vecs[0] = '{"idle",        0, 0, 0, 0, 5'd0,  5'd0, 5'd0,  0, DEF_C};
        vecs[1] = '{"lu_rs",       0, 0, 0, 1, 5'd8,  5'd8, 5'd3,  0, LU_C};
        vecs[2] = '{"lu_release",  0, 0, 0, 0, 5'd8,  5'd8, 5'd3,  0, DEF_C};
        vecs[3] = '{"rt_unused",   0, 0, 0, 1, 5'd8,  5'd2, 5'd8,  0, DEF_C};
        vecs[4] = '{"lu_rt",       0, 0, 0, 1, 5'd8,  5'd2, 5'd8,  1, LU_C};
        vecs[5] = '{"zero_reg",    0, 0, 0, 1, 5'd0,  5'd0, 5'd0,  1, DEF_C};
        vecs[6] = '{"br_over_lu",  0, 0, 1, 1, 5'd8,  5'd8, 5'd8,  1, BR_C};
        vecs[7] = '{"br_only",     0, 0, 1, 0, 5'd0,  5'd4, 5'd5,  1, BR_C};
        vecs[8] = '{"lu_nomatch",  0, 0, 0, 1, 5'd9,  5'd8, 5'd10, 1, DEF_C};
        vecs[9] = '{"lu_r31",      0, 0, 0, 1, 5'd31, 5'd1, 5'd31, 1, LU_C};

        doReset("reset_state");
        foreach (vecs[i])
            applyStimulus(vecs[i].name, vecs[i].r, vecs[i].b, vecs[i].br, vecs[i].mr,
                          vecs[i].exrt, vecs[i].idrs, vecs[i].idrt, vecs[i].ur, vecs[i].exp);
        idle("after_table");

        doReset("sat_reset");
        for (int i = 0; i < 18; i++)
            applyStimulus("sat_stall", 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, LU_C);
        for (int i = 0; i < 18; i++)
            applyStimulus("sat_flush", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, BR_C);
        idle("sat_end");

        doReset("mw_reset");
        for (int i = 0; i < 3; i++)
            applyStimulus("mw_branch_held", 0, 1, 1, 1, 5'd8, 5'd8, 5'd0, 0, MW_C);
        applyStimulus("mw_branch_flush", 0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0, BR_C);
        idle("mw_end");

        doReset("to_reset");
        for (int i = 0; i < 3; i++) busy("to_short_a");
        idle("to_gap");
        for (int i = 0; i < 3; i++) busy("to_short_b");
        idle("to_gap2");
        for (int i = 0; i < 6; i++) busy("to_long");
        idle("to_sticky1");
        idle("to_sticky2");
        doReset("to_clear");
        idle("to_cleared");

        doReset("rmw_reset");
        busy("rmw_busy1");
        applyStimulus("rmw_rst_in_wait", 1, 1, 1, 1, 5'd8, 5'd8, 5'd0, 0, RST_C);
        for (int i = 0; i < 3; i++) busy("rmw_after");
        idle("rmw_no_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
